// File: rtl/shrimp_regfile_pkg.sv
// Shared constants, ABI register indices and helpers for the shrimp register file.
// Optional write-through bypass is selected by the SHRIMP_REGFILE_BYPASS_EN macro.
package shrimp_regfile_pkg;

    localparam int SHRIMP_DATA_W   = 16;
    localparam int SHRIMP_NUM_REGS = 16;

    typedef logic [3:0] reg_addr_t;

    localparam reg_addr_t REG_SP   = 4'hD;
    localparam reg_addr_t REG_RA   = 4'hE;
    localparam reg_addr_t REG_ZERO = 4'hF;

    // The hardwired zero register is always the highest index.
    function automatic int zero_reg_idx(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/shrimp_scoreboard.sv
// Busy-bit scoreboard: issue/writeback/flush priority and registered busy_count.
// SHRIMP_REGFILE_BYPASS_EN lets a same-cycle writeback make issue_ready read as 1.
module shrimp_scoreboard
    import shrimp_regfile_pkg::*;
#(
    parameter int NUM_REGS = SHRIMP_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_enable,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                w_enable,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy,
    output logic                issue_ready,
    output logic [ADDR_W:0]     busy_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(zero_reg_idx(NUM_REGS));

    logic [NUM_REGS-2:0] busy_q;
    logic [NUM_REGS-2:0] busy_d;
    logic [ADDR_W:0]     count_d;
    logic                wb_hit;
    logic                issue_take;

    // Zero register has no storage; its busy bit reads as a constant 0.
    assign busy   = {1'b0, busy_q};
    assign wb_hit = w_enable && (w_addr != ZERO_ADDR);

`ifdef SHRIMP_REGFILE_BYPASS_EN
    assign issue_ready = (issue_addr == ZERO_ADDR) || !busy[issue_addr]
                         || (wb_hit && (w_addr == issue_addr));
`else
    assign issue_ready = (issue_addr == ZERO_ADDR) || !busy[issue_addr];
`endif

    assign issue_take = issue_enable && issue_ready && (issue_addr != ZERO_ADDR) && !flush;

    always_comb begin
        // NOTE: defaults first so every path assigns busy_d and count_d; no latch is inferred.
        busy_d  = busy_q;
        count_d = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (flush || (wb_hit && (w_addr == ADDR_W'(i)))) begin
                busy_d[i] = 1'b0;
            end
            // A newer issue's claim survives a same-cycle writeback to that register.
            if (issue_take && (issue_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (reset) begin
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_count <= count_d;
        end
    end

endmodule

// File: rtl/shrimp_regfile_sb.sv
// Parametrised register file with hardwired zero register and busy scoreboard.
// SHRIMP_REGFILE_BYPASS_EN enables write-through bypass on the read ports.
module shrimp_regfile_sb
    import shrimp_regfile_pkg::*;
#(
    parameter  int DATA_W     = SHRIMP_DATA_W,
    parameter  int NUM_REGS   = SHRIMP_NUM_REGS,
    parameter  int READ_PORTS = 2,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
    output logic [READ_PORTS*DATA_W-1:0] rd_val,
    output logic [READ_PORTS-1:0]        rd_busy,
    input  logic                         w_enable,
    input  logic [ADDR_W-1:0]            w_addr,
    input  logic [DATA_W-1:0]            w_val,
    input  logic                         issue_enable,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         issue_ready,
    input  logic                         flush,
    output logic [ADDR_W:0]              busy_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(zero_reg_idx(NUM_REGS));

    logic [DATA_W-1:0]   data_q [NUM_REGS-1];
    logic [NUM_REGS-1:0] busy;
    logic                wb_hit;

    assign wb_hit = w_enable && (w_addr != ZERO_ADDR);

    shrimp_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .issue_enable (issue_enable),
        .issue_addr   (issue_addr),
        .w_enable     (w_enable),
        .w_addr       (w_addr),
        .flush        (flush),
        .busy         (busy),
        .issue_ready  (issue_ready),
        .busy_count   (busy_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the array is built from flops, not a RAM macro, so clearing it on reset is legal and intended.
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                data_q[i] <= '0;
            end
        end else if (wb_hit) begin
            data_q[w_addr] <= w_val;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;

        assign addr   = rd_addr[p*ADDR_W +: ADDR_W];
        assign stored = (addr == ZERO_ADDR) ? '0 : data_q[addr];

`ifdef SHRIMP_REGFILE_BYPASS_EN
        logic hit;
        assign hit                       = wb_hit && (w_addr == addr);
        assign rd_val[p*DATA_W +: DATA_W] = hit ? w_val : stored;
        assign rd_busy[p]                = !hit && busy[addr];
`else
        assign rd_val[p*DATA_W +: DATA_W] = stored;
        assign rd_busy[p]                = busy[addr];
`endif
    end

endmodule

// File: tb/tb_shrimp_regfile_sb.sv
// Scoreboard bench for shrimp_regfile_sb: driver pushes model expectations, monitor pops and compares.
// Expectations follow SHRIMP_REGFILE_BYPASS_EN when it is defined for the build.
module tb_shrimp_regfile_sb #(
    parameter int DATA_W     = 16,
    parameter int NUM_REGS   = 16,
    parameter int READ_PORTS = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int ZERO   = NUM_REGS - 1;

`ifdef SHRIMP_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                         clock;
    logic                         reset;
    logic [READ_PORTS*ADDR_W-1:0] rd_addr;
    logic [READ_PORTS*DATA_W-1:0] rd_val;
    logic [READ_PORTS-1:0]        rd_busy;
    logic                         w_enable;
    logic [ADDR_W-1:0]            w_addr;
    logic [DATA_W-1:0]            w_val;
    logic                         issue_enable;
    logic [ADDR_W-1:0]            issue_addr;
    logic                         issue_ready;
    logic                         flush;
    logic [ADDR_W:0]              busy_count;

    shrimp_regfile_sb #(
        .DATA_W     (DATA_W),
        .NUM_REGS   (NUM_REGS),
        .READ_PORTS (READ_PORTS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_val       (rd_val),
        .rd_busy      (rd_busy),
        .w_enable     (w_enable),
        .w_addr       (w_addr),
        .w_val        (w_val),
        .issue_enable (issue_enable),
        .issue_addr   (issue_addr),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .busy_count   (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic                         rst;
        logic [READ_PORTS*ADDR_W-1:0] ra;
        logic                         we;
        logic [ADDR_W-1:0]            wa;
        logic [DATA_W-1:0]            wv;
        logic                         ie;
        logic [ADDR_W-1:0]            ia;
        logic                         fl;
    } stim_t;

    typedef struct {
        int                           cyc;
        logic [READ_PORTS*DATA_W-1:0] val;
        logic [READ_PORTS-1:0]        busy;
        logic                         ready;
        logic [ADDR_W:0]              count;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays indexed by register number.
    logic [DATA_W-1:0] m_data [NUM_REGS];
    bit                m_busy [NUM_REGS];
    bit                m_known = 1'b0;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check(input string name, input int at, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, at, got, want);
        end
    endtask

    function automatic bit model_ready(input stim_t s);
        if (int'(s.ia) == ZERO) return 1'b1;
        if (BYPASS && s.we && s.wa == s.ia) return 1'b1;
        return !m_busy[s.ia];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.we = 1'b0; s.wa = '0; s.wv = '0;
        s.ie  = 1'b0; s.ia = '0;   s.fl = 1'b0;
        for (int p = 0; p < READ_PORTS; p++)
            s.ra[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(NUM_REGS - 1));
        return s;
    endfunction

    function automatic stim_t set_port(input stim_t s, input int p, input int a);
        stim_t r = s;
        r.ra[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
        return r;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   ready;
        int   cnt;
        @(posedge clock);
        #2;
        reset = s.rst; rd_addr = s.ra; w_enable = s.we; w_addr = s.wa; w_val = s.wv;
        issue_enable = s.ie; issue_addr = s.ia; flush = s.fl;
        cyc++;
        ready = model_ready(s);
        if (m_known) begin
            e.cyc = cyc;
            for (int p = 0; p < READ_PORTS; p++) begin
                int a = int'(s.ra[p*ADDR_W +: ADDR_W]);
                bit hit = BYPASS && s.we && (int'(s.wa) == a) && (a != ZERO);
                e.val[p*DATA_W +: DATA_W] = (a == ZERO) ? '0 : (hit ? s.wv : m_data[a]);
                e.busy[p] = (a != ZERO) && !hit && m_busy[a];
            end
            e.ready = ready;
            cnt = 0;
            for (int i = 0; i < NUM_REGS; i++) cnt += int'(m_busy[i]);
            e.count = (ADDR_W+1)'(cnt);
            exp_q.push_back(e);
        end
        if (s.rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin m_data[i] = '0; m_busy[i] = 1'b0; end
            m_known = 1'b1;
        end else begin
            if (s.we && int'(s.wa) != ZERO) begin m_data[s.wa] = s.wv; m_busy[s.wa] = 1'b0; end
            if (s.fl) begin
                for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
            end else if (s.ie && ready && int'(s.ia) != ZERO) begin
                m_busy[s.ia] = 1'b1;
            end
        end
    endtask

    // Monitor: outputs are combinational, so one expectation is due every driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #4;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < READ_PORTS; p++) begin
                    check($sformatf("rd_val[%0d]", p), e.cyc, 64'(rd_val[p*DATA_W +: DATA_W]),
                          64'(e.val[p*DATA_W +: DATA_W]));
                    check($sformatf("rd_busy[%0d]", p), e.cyc, 64'(rd_busy[p]), 64'(e.busy[p]));
                end
                check("issue_ready", e.cyc, 64'(issue_ready), 64'(e.ready));
                check("busy_count", e.cyc, 64'(busy_count), 64'(e.count));
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; rd_addr = '0; w_enable = 1'b0; w_addr = '0; w_val = '0;
        issue_enable = 1'b0; issue_addr = '0; flush = 1'b0;

        // Reset dominates a same-cycle write and issue.
        s = idle(); s.rst = 1'b1; s.we = 1'b1; s.wa = ADDR_W'(3); s.wv = DATA_W'(16'hDEAD);
        s.ie = 1'b1; s.ia = ADDR_W'(2); step(s);
        s = idle(); s.rst = 1'b1; step(s);

        for (int a = 0; a < NUM_REGS; a++) begin
            s = idle();
            for (int p = 0; p < READ_PORTS; p++) s = set_port(s, p, a);
            step(s);
        end

        // Writes to the zero register are discarded.
        s = idle(); s.we = 1'b1; s.wa = ADDR_W'(ZERO); s.wv = DATA_W'(16'hBEEF); s = set_port(s, 0, ZERO); step(s);
        s = idle(); s = set_port(s, 0, ZERO); s.ie = 1'b1; s.ia = ADDR_W'(ZERO); step(s);

        // Issue 3 twice, then write it back.
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(3); s = set_port(s, 0, 3); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(3); s = set_port(s, 0, 3); step(s);
        s = idle(); s.we = 1'b1; s.wa = ADDR_W'(3); s.wv = DATA_W'(16'h1234); s = set_port(s, 0, 3); step(s);
        s = idle(); s = set_port(s, 0, 3); s.ia = ADDR_W'(3); step(s);

        // Same-cycle issue and writeback to a busy register, then retry.
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(5); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(5); s.we = 1'b1; s.wa = ADDR_W'(5);
        s.wv = DATA_W'(16'h00AA); s = set_port(s, 0, 5); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(5); s = set_port(s, 0, 5); step(s);
        s = idle(); s = set_port(s, 0, 5); s.ia = ADDR_W'(5); step(s);

        // Same-cycle issue and writeback to a free register: busy ends set.
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(6); s.we = 1'b1; s.wa = ADDR_W'(6);
        s.wv = DATA_W'(16'h6666); s = set_port(s, 0, 6); step(s);
        s = idle(); s = set_port(s, 0, 6); s.ia = ADDR_W'(6); step(s);

        // Flush with a same-cycle writeback and a dropped issue.
        s = idle(); s.we = 1'b1; s.wa = ADDR_W'(1); s.wv = DATA_W'(16'h1111); step(s);
        s = idle(); s.we = 1'b1; s.wa = ADDR_W'(7); s.wv = DATA_W'(16'h7777); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(1); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(2); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(7); step(s);
        s = idle(); s.fl = 1'b1; s.we = 1'b1; s.wa = ADDR_W'(2); s.wv = DATA_W'(16'h5555);
        s.ie = 1'b1; s.ia = ADDR_W'(0); step(s);
        s = idle(); s = set_port(s, 0, 1); s = set_port(s, 1, 2); s.ia = ADDR_W'(0); step(s);
        s = idle(); s = set_port(s, 0, 7); s = set_port(s, 1, 2); step(s);

        // Writeback visibility on the read port (bypass or next cycle).
        s = idle(); s.we = 1'b1; s.wa = ADDR_W'(4); s.wv = DATA_W'(16'h4444); step(s);
        s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(4); step(s);
        s = idle(); s.we = 1'b1; s.wa = ADDR_W'(4); s.wv = DATA_W'(16'h0F0F); s = set_port(s, 0, 4);
        s.ie = 1'b1; s.ia = ADDR_W'(4); step(s);
        s = idle(); s = set_port(s, 0, 4); s.ia = ADDR_W'(4); step(s);

        // Fill every real register so busy_count reaches its maximum.
        for (int a = 0; a < NUM_REGS; a++) begin
            s = idle(); s.ie = 1'b1; s.ia = ADDR_W'(a); step(s);
        end
        s = idle(); step(s);

        // Random traffic with occasional flush and mid-run reset.
        for (int n = 0; n < 800; n++) begin
            s = idle();
            s.rst = ($urandom_range(99) == 0);
            s.fl  = ($urandom_range(19) == 0);
            s.we  = 1'($urandom_range(1));
            s.wa  = ADDR_W'($urandom_range(NUM_REGS - 1));
            s.wv  = DATA_W'($urandom);
            s.ie  = ($urandom_range(2) != 0);
            s.ia  = ADDR_W'($urandom_range(NUM_REGS - 1));
            if ($urandom_range(3) == 0) s = set_port(s, 0, int'(s.wa));
            step(s);
        end

        repeat (3) @(posedge clock);
        #6;
        check("queue_drain", cyc, 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
